// File: rtl/mips_encode_pkg.sv
// Shared constants and types for the MIPS arithmetic instruction encoder.
// Used by mips_encode (top) and mips_encode_lut.
package mips_encode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_XOR  = 6'h26;

  localparam logic [2:0] ALU_ADDU = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_OR   = 3'b101;
  localparam logic [2:0] ALU_NOR  = 3'b110;
  localparam logic [2:0] ALU_XOR  = 3'b111;

  typedef enum logic [1:0] {
    SRC_REG  = 2'd0,
    SRC_SEXT = 2'd1,
    SRC_ZEXT = 2'd2
  } alu_src2_e;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  typedef struct packed {
    logic [31:0] instr;
    logic        except;
  } enc_word_t;

endpackage

// File: rtl/mips_encode_lut.sv
// Combinational map from (alu_src2, alu_op) plus register/immediate fields
// to a canonical R- or I-type word; unencodable combinations flag except.
module mips_encode_lut
  import mips_encode_pkg::*;
(
  input  logic [2:0]  alu_op,
  input  logic [1:0]  alu_src2,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  output enc_word_t   word
);

  logic [5:0] funct;
  logic [5:0] opcode;
  logic       r_ok;
  logic       i_ok;

  always_comb begin
    funct  = 6'h00;
    opcode = 6'h00;
    r_ok   = 1'b0;
    i_ok   = 1'b0;
    case (alu_src2)
      SRC_REG: begin
        r_ok = 1'b1;
        case (alu_op)
          ALU_ADDU: funct = FN_ADDU;
          ALU_ADD:  funct = FN_ADD;
          ALU_SUB:  funct = FN_SUB;
          ALU_AND:  funct = FN_AND;
          ALU_OR:   funct = FN_OR;
          ALU_NOR:  funct = FN_NOR;
          ALU_XOR:  funct = FN_XOR;
          default:  r_ok  = 1'b0;
        endcase
      end
      SRC_SEXT: begin
        i_ok = 1'b1;
        case (alu_op)
          ALU_ADD:  opcode = OP_ADDI;
          ALU_ADDU: opcode = OP_ADDIU;
          default:  i_ok   = 1'b0;
        endcase
      end
      SRC_ZEXT: begin
        i_ok = 1'b1;
        case (alu_op)
          ALU_AND: opcode = OP_ANDI;
          ALU_OR:  opcode = OP_ORI;
          ALU_XOR: opcode = OP_XORI;
          default: i_ok   = 1'b0;
        endcase
      end
      default: ;
    endcase

    // Illegal combinations emit an all-zero word flagged as an exception.
    word.instr  = 32'h0000_0000;
    word.except = 1'b1;
    if (r_ok) begin
      word.instr  = {OP_RTYPE, rs, rt, rd, 5'd0, funct};
      word.except = 1'b0;
    end else if (i_ok) begin
      word.instr  = {opcode, rs, rt, imm};
      word.except = 1'b0;
    end
  end

endmodule

// File: rtl/mips_encode.sv
// Streaming MIPS arithmetic encoder with a two-slot valid/ready skid stage.
// Define MIPS_ENCODE_STATS_EN to build the saturating delivery counters.
module mips_encode
  import mips_encode_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_op,
  input  logic [1:0]       alu_src2,
  input  logic [4:0]       rs,
  input  logic [4:0]       rt,
  input  logic [4:0]       rd,
  input  logic [15:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_except,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] exc_count
);

  enc_word_t enc_p0;
  enc_word_t out_p1;
  enc_word_t skid_p1;
  occ_e      occ_q;
  occ_e      occ_d;
  logic      accept;
  logic      consume;
  logic      load_out;
  logic      load_skid;
  logic      skid_to_out;

  // Stage p0: combinational encode of the incoming request.
  mips_encode_lut u_lut (
    .alu_op   (alu_op),
    .alu_src2 (alu_src2),
    .rs       (rs),
    .rt       (rt),
    .rd       (rd),
    .imm      (imm),
    .word     (enc_p0)
  );

  assign accept  = in_valid && in_ready;
  assign consume = out_valid && out_ready;

  always_comb begin
    occ_d       = occ_q;
    load_out    = 1'b0;
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
    case (occ_q)
      OCC_EMPTY: begin
        if (accept) begin
          load_out = 1'b1;
          occ_d    = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (consume) begin
          if (accept) load_out = 1'b1;
          else        occ_d    = OCC_EMPTY;
        end else if (accept) begin
          load_skid = 1'b1;
          occ_d     = OCC_FULL;
        end
      end
      OCC_FULL: begin
        if (consume) begin
          skid_to_out = 1'b1;
          if (accept) load_skid = 1'b1;
          else        occ_d     = OCC_ONE;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
  end

  // Stage p1: output slot and occupancy; in_ready mirrors "skid empty next".
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      occ_q    <= OCC_EMPTY;
      in_ready <= 1'b1;
      out_p1   <= '0;
    end else begin
      occ_q    <= occ_d;
      in_ready <= (occ_d != OCC_FULL);
      if (load_out)         out_p1 <= enc_p0;
      else if (skid_to_out) out_p1 <= skid_p1;
    end
  end

  always_ff @(posedge clock) begin
    if (load_skid) skid_p1 <= enc_p0;
  end

  assign out_valid  = (occ_q != OCC_EMPTY);
  assign out_instr  = out_p1.instr;
  assign out_except = out_p1.except;

`ifdef MIPS_ENCODE_STATS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      enc_count <= '0;
      exc_count <= '0;
    end else if (consume) begin
      if (out_p1.except) begin
        if (exc_count != '1) exc_count <= exc_count + 1'b1;
      end else begin
        if (enc_count != '1) enc_count <= enc_count + 1'b1;
      end
    end
  end
`else
  assign enc_count = '0;
  assign exc_count = '0;
`endif

endmodule
